// File: rtl/mms_pkg.sv
// Shared ITLB refill types: FSM encoding, PTW request/response payloads,
// entry count and field widths.
`ifndef TLB_ENTRY_SIZE
`define TLB_ENTRY_SIZE 32
`endif

package mms_pkg;

  localparam int ENTRY_NUM = `TLB_ENTRY_SIZE;
  localparam int VPN_W     = 27;
  localparam int PPN_W     = 44;
  localparam int PERM_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FAULT = 3'd4
  } itlb_refill_state_e;

  typedef struct packed {
    logic [VPN_W-1:0] vpn;
  } ptw_req_t;

  typedef struct packed {
    logic [PPN_W-1:0]  ppn;
    logic [PERM_W-1:0] perm;
    logic              fault;
  } ptw_rsp_t;

endpackage

// File: rtl/itlb_refill_ctrl.sv
// ITLB miss/refill controller. Takes one lookup miss at a time, walks it
// through the shared PTW, and writes the result into the PLRU-selected
// victim entry while maintaining the entry-valid vector.
// Optional build macro: MMS_ITLB_PERF_CNT_EN adds saturating miss/fault/drop
// counters; without it the counter ports read as zero.
module itlb_refill_ctrl
  import mms_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 miss_vld_i,
  input  logic [VPN_W-1:0]     miss_vpn_i,
  output logic                 miss_rdy_o,
  output logic                 ptw_req_vld_o,
  input  logic                 ptw_req_rdy_i,
  output logic [VPN_W-1:0]     ptw_req_vpn_o,
  input  logic                 ptw_rsp_vld_i,
  input  logic [PPN_W-1:0]     ptw_rsp_ppn_i,
  input  logic [PERM_W-1:0]    ptw_rsp_perm_i,
  input  logic                 ptw_rsp_fault_i,
  input  logic [ENTRY_NUM-1:0] victim_onehot_i,
  output logic [ENTRY_NUM-1:0] entry_valid_o,
  output logic                 refill_init_en_o,
  output logic                 refill_vld_o,
  output logic [ENTRY_NUM-1:0] refill_onehot_o,
  output logic [VPN_W-1:0]     refill_vpn_o,
  output logic [PPN_W-1:0]     refill_ppn_o,
  output logic [PERM_W-1:0]    refill_perm_o,
  output logic                 fault_vld_o,
  output logic [VPN_W-1:0]     fault_vpn_o,
  output logic                 busy_o,
  output logic [31:0]          miss_cnt_o,
  output logic [31:0]          fault_cnt_o,
  output logic [31:0]          drop_cnt_o
);

  itlb_refill_state_e   state_q, state_d;
  ptw_req_t             req_q;
  ptw_rsp_t             rsp_q;
  logic                 drop_q;
  logic [ENTRY_NUM-1:0] valid_q;
  logic                 miss_acc;
  logic                 rsp_drop;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-state strobes. A flush arriving together with the
  // response in WAIT drops it too, so a stale translation never lands in a
  // freshly flushed array.
  always_comb begin
    state_d          = state_q;
    miss_rdy_o       = 1'b0;
    refill_init_en_o = 1'b0;
    ptw_req_vld_o    = 1'b0;
    refill_vld_o     = 1'b0;
    refill_onehot_o  = '0;
    fault_vld_o      = 1'b0;
    miss_acc         = 1'b0;
    rsp_drop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miss_rdy_o = !flush_i;
        if (miss_vld_i && !flush_i) begin
          miss_acc         = 1'b1;
          refill_init_en_o = 1'b1;
          state_d          = ST_REQ;
        end
      end
      ST_REQ: begin
        ptw_req_vld_o = 1'b1;
        if (ptw_req_rdy_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ptw_rsp_vld_i) begin
          if (drop_q || flush_i) begin
            rsp_drop = 1'b1;
            state_d  = ST_IDLE;
          end else if (ptw_rsp_fault_i) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        refill_vld_o    = !flush_i;
        refill_onehot_o = victim_onehot_i;
        state_d         = ST_IDLE;
      end
      ST_FAULT: begin
        fault_vld_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // VPN/response latches, drop flag and entry-valid vector.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q   <= '0;
      rsp_q   <= '0;
      drop_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      if (miss_acc) req_q.vpn <= miss_vpn_i;
      if (state_q == ST_WAIT && ptw_rsp_vld_i && !rsp_drop)
        rsp_q <= '{ppn: ptw_rsp_ppn_i, perm: ptw_rsp_perm_i, fault: ptw_rsp_fault_i};
      if (rsp_drop)
        drop_q <= 1'b0;
      else if (flush_i && (state_q == ST_REQ || state_q == ST_WAIT))
        drop_q <= 1'b1;
      if (flush_i)           valid_q <= '0;
      else if (refill_vld_o) valid_q <= valid_q | victim_onehot_i;
    end
  end

  assign ptw_req_vpn_o = req_q.vpn;
  assign refill_vpn_o  = req_q.vpn;
  assign refill_ppn_o  = rsp_q.ppn;
  assign refill_perm_o = rsp_q.perm;
  assign fault_vpn_o   = req_q.vpn;
  assign entry_valid_o = valid_q;
  assign busy_o        = (state_q != ST_IDLE);

`ifdef MMS_ITLB_PERF_CNT_EN
  logic [31:0] miss_cnt_q, fault_cnt_q, drop_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_cnt_q  <= '0;
      fault_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (miss_acc    && miss_cnt_q  != '1) miss_cnt_q  <= miss_cnt_q  + 32'd1;
      if (fault_vld_o && fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + 32'd1;
      if (rsp_drop    && drop_cnt_q  != '1) drop_cnt_q  <= drop_cnt_q  + 32'd1;
    end
  end

  assign miss_cnt_o  = miss_cnt_q;
  assign fault_cnt_o = fault_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`else
  assign miss_cnt_o  = '0;
  assign fault_cnt_o = '0;
  assign drop_cnt_o  = '0;
`endif

`ifndef SYNTHESIS
  // The PLRU must present exactly one victim whenever an entry is written.
  always_ff @(posedge clk_i) begin
    if (!rst_i && refill_vld_o)
      assert ($onehot(victim_onehot_i))
        else $error("itlb_refill_ctrl: victim_onehot_i not one-hot: %h", victim_onehot_i);
  end
`endif

endmodule

// File: doc/itlb_refill_ctrl.md
Name: itlb_refill_ctrl

Overview:
ITLB miss/refill controller that drives the ITLB replacement logic. It accepts a lookup miss and issues a page-table-walk (PTW) request. On a good PTW response it writes the translation into the victim entry chosen by the PLRU, and it maintains the entry-valid vector that the PLRU uses for victim selection. It sits between the ITLB lookup stage, the PLRU, the ITLB entry array and the shared PTW.

Parameters:
ENTRY_NUM, `TLB_ENTRY_SIZE (32), number of ITLB entries.
VPN_W, 27, virtual page number width (Sv39).
PPN_W, 44, physical page number width.
PERM_W, 8, PTE flag bits (V R W X U G A D).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  invalidate all entries (sfence.vma)
miss_vld_i  in  1  lookup missed
miss_vpn_i  in  VPN_W  missing VPN
miss_rdy_o  out  1  controller can accept a miss
ptw_req_vld_o  out  1  PTW request valid
ptw_req_rdy_i  in  1  PTW request accepted
ptw_req_vpn_o  out  VPN_W  VPN to walk
ptw_rsp_vld_i  in  1  PTW response valid
ptw_rsp_ppn_i  in  PPN_W  returned PPN
ptw_rsp_perm_i  in  PERM_W  returned flags
ptw_rsp_fault_i  in  1  walk faulted
victim_onehot_i  in  ENTRY_NUM  victim one-hot from PLRU
entry_valid_o  out  ENTRY_NUM  per-entry valid, to PLRU and array
refill_init_en_o  out  1  PLRU victim-latch strobe
refill_vld_o  out  1  entry write strobe, also PLRU write update
refill_onehot_o  out  ENTRY_NUM  entry write select
refill_vpn_o  out  VPN_W  tag to write
refill_ppn_o  out  PPN_W  PPN to write
refill_perm_o  out  PERM_W  flags to write
fault_vld_o  out  1  one-cycle page-fault report
fault_vpn_o  out  VPN_W  faulting VPN
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE; entry_valid_o=0; drop flag=0. All *_vld_o, refill_init_en_o and busy_o are 0. All data outputs are 0. A reset mid-walk abandons the walk, and any later PTW response is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, WRITE, FAULT.
- IDLE:
  - miss_rdy_o = !flush_i.
  - miss_vld_i && miss_rdy_o: latch the VPN, assert refill_init_en_o combinationally in the same cycle, then go to REQ.
- REQ:
  - ptw_req_vld_o=1 with the latched VPN.
  - The VPN is held stable and vld is never withdrawn until ptw_req_rdy_i is seen; then go to WAIT.
- WAIT:
  - On ptw_rsp_vld_i: if the drop flag is set, discard the response, clear the flag and go to IDLE.
  - Else if fault: latch the VPN and go to FAULT.
  - Else: latch PPN and flags and go to WRITE.
- WRITE:
  - refill_vld_o=1 for exactly one cycle.
  - refill_onehot_o=victim_onehot_i; the VPN/PPN/flags come from the latches.
  - entry_valid_o |= victim_onehot_i at the next edge; then go to IDLE.
- FAULT: fault_vld_o=1 for one cycle, no entry write; go to IDLE.
- Best-case latency: miss accepted in cycle 0 → REQ cycle 1 (rdy=1) → WAIT cycle 2 (rsp) → WRITE cycle 3 → IDLE cycle 4.
- flush_i, any state: entry_valid_o=0 at the next edge.
  - Flush in REQ or WAIT sets the drop flag; the request handshake still completes.
  - Flush in WRITE gates refill_vld_o low; no write and no valid set; go to IDLE.
  - Flush in FAULT: the fault is still reported.
- Flush and miss in the same IDLE cycle: flush wins and the miss is not accepted.
- victim_onehot_i is sampled only in WRITE and must be exactly one-hot; a simulation assertion checks this.
- Only one miss is outstanding at a time; there is no miss queueing.

Optional Feature:
MMS_ITLB_PERF_CNT_EN: when defined, the block adds three 32-bit saturating counters, all cleared by reset:
- miss_cnt_o: accepted misses.
- fault_cnt_o: faults reported.
- drop_cnt_o: responses dropped due to flush.

When undefined, the ports still exist and are tied to 0, and no counter flops are built.

Decomposition:
- mms_pkg holds:
  - itlb_refill_state_e enum.
  - ptw_req_t {vpn} and ptw_rsp_t {ppn, perm, fault} packed structs.
  - `TLB_ENTRY_SIZE.
  - VPN_W, PPN_W and PERM_W localparams.
- No sub-module: the FSM, latches and valid vector live in one module.
- The counters sit in the generate/`ifdef block.

Test Plan:
- Reset then miss of VPN 0x1234, rdy=1, good rsp PPN 0xABC in cycle 2:
  - refill_init_en_o pulses in cycle 0.
  - refill_vld_o is high in cycle 3 with onehot=0x1, vpn 0x1234, ppn 0xABC.
  - entry_valid_o=0x1 in cycle 4.
- 32 consecutive refills with the victim fed as the lowest invalid entry → entry_valid_o=0xFFFFFFFF; a 33rd refill with victim 0x00010000 leaves valid unchanged.
- PTW rsp with fault=1 for VPN 0x55 → fault_vld_o high for exactly one cycle with fault_vpn_o=0x55; no refill_vld_o; valid unchanged.
- flush_i in WAIT, then rsp arrives → response dropped, no refill_vld_o, entry_valid_o=0, FSM in IDLE.
- ptw_req_rdy_i held low for 5 cycles → ptw_req_vld_o and VPN stable throughout; miss_rdy_o=0 and busy_o=1.
- flush_i and miss_vld_i in the same IDLE cycle → miss not accepted, refill_init_en_o=0, entry_valid_o cleared.
